left_rotate_seq: RTL and testbench

Left-rotate register with a small sequencer. It is the counterpart of the team's right-rotate register: it loads a DW-bit word, then, on a start command, rotates it left by a programmable amount per cycle for a programmed number of cycles. It reports busy and a one-cycle done pulse. It sits in the register/shift-utility group and is driven by simple control logic or a bench.

---
 rtl/left_rotate_seq.sv | 134 +++++++++++++
 tb/tb_left_rotate_seq.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/left_rotate_seq.sv
// Load-and-rotate register with a start/busy/done sequencer.
// Define ROT_DIR_SEL_EN to add a dir input selecting right rotation.
module left_rotate_seq #(
  parameter int DW    = 4,
  parameter int AMT_W = $clog2(DW),
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             async_rst_n,
  input  logic             load,
  input  logic [DW-1:0]    data,
  input  logic             start,
  input  logic [AMT_W-1:0] amt,
  input  logic [CNT_W-1:0] nrot,
`ifdef ROT_DIR_SEL_EN
  input  logic             dir,
`endif
  output logic [DW-1:0]    q,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] rot_left
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROT  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [DW-1:0]    q_nx;
  logic [AMT_W-1:0] amt_r, amt_nx;
  logic [AMT_W-1:0] amt_mod;
  logic [CNT_W-1:0] left_nx;
  logic [DW-1:0]    rot_l;
`ifdef ROT_DIR_SEL_EN
  logic             dir_r, dir_nx;
  logic [DW-1:0]    rot_r;
`endif

  // Reduce once at sampling so amt_r is always a legal index
  assign amt_mod = AMT_W'(32'(amt) % DW);

  always_comb begin
    rot_l = '0;
    for (int i = 0; i < DW; i++) begin
      rot_l[i] = q[(i + DW - int'(amt_r)) % DW];
    end
  end

`ifdef ROT_DIR_SEL_EN
  always_comb begin
    rot_r = '0;
    for (int i = 0; i < DW; i++) begin
      rot_r[i] = q[(i + int'(amt_r)) % DW];
    end
  end
`endif

  always_comb begin
    state_nx = state;
    q_nx     = q;
    amt_nx   = amt_r;
    left_nx  = rot_left;
`ifdef ROT_DIR_SEL_EN
    dir_nx   = dir_r;
`endif
    unique case (state)
      IDLE: begin
        if (load) begin
          q_nx = data;
        end else if (start) begin
          if (nrot != '0) begin
            amt_nx   = amt_mod;
            left_nx  = nrot;
`ifdef ROT_DIR_SEL_EN
            dir_nx   = dir;
`endif
            state_nx = ROT;
          end else begin
            state_nx = DONE;
          end
        end
      end
      ROT: begin
`ifdef ROT_DIR_SEL_EN
        q_nx = dir_r ? rot_r : rot_l;
`else
        q_nx = rot_l;
`endif
        left_nx = rot_left - CNT_W'(1);
        if (rot_left == CNT_W'(1)) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        left_nx  = '0;
        state_nx = IDLE;
      end
      default: begin
        left_nx  = '0;
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state    <= IDLE;
      q        <= '0;
      amt_r    <= '0;
      rot_left <= '0;
    end else begin
      state    <= state_nx;
      q        <= q_nx;
      amt_r    <= amt_nx;
      rot_left <= left_nx;
    end
  end

`ifdef ROT_DIR_SEL_EN
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      dir_r <= 1'b0;
    end else begin
      dir_r <= dir_nx;
    end
  end
`endif

  assign busy = (state == ROT);
  assign done = (state == DONE);

endmodule

// File: tb/tb_left_rotate_seq.sv
// Bench for left_rotate_seq: directed and random sequences
// checked against an arithmetic rotation model.
module tb_left_rotate_seq;

  localparam int DW    = 4;
  localparam int AMT_W = 2;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             async_rst_n;
  logic             load;
  logic [DW-1:0]    data;
  logic             start;
  logic [AMT_W-1:0] amt;
  logic [CNT_W-1:0] nrot;
  logic             dir;
  logic [DW-1:0]    q;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] rot_left;

  int checks = 0;
  int errors = 0;

  left_rotate_seq #(.DW(DW), .AMT_W(AMT_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .async_rst_n(async_rst_n),
    .load       (load),
    .data       (data),
    .start      (start),
    .amt        (amt),
    .nrot       (nrot),
`ifdef ROT_DIR_SEL_EN
    .dir        (dir),
`endif
    .q          (q),
    .busy       (busy),
    .done       (done),
    .rot_left   (rot_left)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Total rotation after i cycles is i*amt positions, taken mod DW
  function automatic logic [DW-1:0] model_rot(input logic [DW-1:0] v,
                                              input int s, input bit right);
    int k = s % DW;
    int x = int'(v);
    int m = (1 << DW) - 1;
    if (right) k = (DW - k) % DW;
    if (k == 0) return v;
    return DW'(((x << k) | (x >> (DW - k))) & m);
  endfunction

  task automatic run_seq(input logic [DW-1:0] d, input int a,
                         input int n, input bit right);
    logic [DW-1:0] exp_q;
    bit rd;
`ifdef ROT_DIR_SEL_EN
    rd = right;
`else
    rd = 1'b0;
`endif
    load = 1'b1; data = d; start = 1'b0;
    tick();
    chk("load_q", q, d);
    load = 1'b0;
    start = 1'b1; amt = AMT_W'(a); nrot = CNT_W'(n); dir = right;
    tick();
    // Hostile inputs while the sequence runs
    load = 1'b1; start = 1'b1; data = DW'($urandom);
    amt = AMT_W'($urandom); nrot = CNT_W'($urandom_range(1, 255));
    dir = 1'(~right);
    if (n == 0) begin
      chk("z_busy", busy, 0);
      chk("z_done", done, 1);
      chk("z_q", q, d);
      chk("z_left", rot_left, 0);
    end else begin
      chk("s_busy", busy, 1);
      chk("s_done", done, 0);
      chk("s_q", q, d);
      chk("s_left", rot_left, n);
      for (int i = 1; i <= n; i++) begin
        tick();
        exp_q = model_rot(d, a * i, rd);
        chk("r_q", q, exp_q);
        chk("r_left", rot_left, n - i);
        chk("r_busy", busy, i < n);
        chk("r_done", done, i == n);
      end
    end
    exp_q = model_rot(d, a * n, rd);
    tick();
    load = 1'b0; start = 1'b0;
    chk("e_done", done, 0);
    chk("e_busy", busy, 0);
    chk("e_q", q, exp_q);
    chk("e_left", rot_left, 0);
  endtask

  initial begin
    async_rst_n = 1'b0;
    load = 1'b0; data = '0; start = 1'b0;
    amt = '0; nrot = '0; dir = 1'b0;
    tick();
    tick();
    chk("rst_q", q, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_left", rot_left, 0);
    async_rst_n = 1'b1;

    load = 1'b1; data = 4'b1001;
    tick();
    load = 1'b0; data = 4'b0110;
    chk("t1_q", q, 4'b1001);
    chk("t1_busy", busy, 0);
    chk("t1_done", done, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t1_hold", q, 4'b1001);
    end

    run_seq(4'b0001, 1, 3, 1'b0);
    run_seq(4'b1011, 2, 2, 1'b0);
    run_seq(4'b0110, 3, 0, 1'b0);

    load = 1'b1; start = 1'b1; data = 4'b1100; amt = 2'd1; nrot = 8'd3;
    tick();
    load = 1'b0; start = 1'b0;
    chk("ls_q", q, 4'b1100);
    chk("ls_busy", busy, 0);
    tick();
    chk("ls_busy2", busy, 0);
    chk("ls_done", done, 0);
    chk("ls_q2", q, 4'b1100);

    run_seq(4'b0001, 1, 4, 1'b0);

    load = 1'b1; data = 4'b0001;
    tick();
    load = 1'b0; start = 1'b1; amt = 2'd1; nrot = 8'd5;
    tick();
    start = 1'b0;
    tick();
    chk("mr_q", q, 4'b0010);
    #2 async_rst_n = 1'b0;
    #1;
    chk("mr_q0", q, 0);
    chk("mr_busy", busy, 0);
    chk("mr_left", rot_left, 0);
    chk("mr_done", done, 0);
    tick();
    async_rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("ar_done", done, 0);
      chk("ar_busy", busy, 0);
    end

`ifdef ROT_DIR_SEL_EN
    run_seq(4'b1000, 1, 3, 1'b1);
`endif

    for (int t = 0; t < 25; t++) begin
      run_seq(DW'($urandom), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 12)), 1'($urandom));
    end

    run_seq(4'b0011, 1, 255, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
